// File: rtl/video_stream_pkg.sv
// Shared encodings for the packed 24-bit video stream (packer and unpacker).
// Three 32-bit words carry four 24-bit pixels; the phase says which word is next.
package video_stream_pkg;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    localparam logic [1:0] PH_W0 = 2'd0;
    localparam logic [1:0] PH_W1 = 2'd1;
    localparam logic [1:0] PH_W2 = 2'd2;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_HOLD2 = 2'd2;

    function automatic logic [1:0] phase_next(input logic [1:0] ph);
        return (ph == PH_W2) ? PH_W0 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/pixel_counter.sv
// Position of the presented pixel plus the position the next loaded pixel will take.
// A load may restart the frame (sync) or end the line early after this pixel (brk).
module pixel_counter
    import video_stream_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       load,
    input  logic       sync,
    input  logic       brk,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic [9:0] next_x,
    output logic [8:0] next_y,
    output logic       pix_sof,
    output logic       pix_eol
);

    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    logic [9:0] x_q, x_d, nx_q, nx_d, px;
    logic [8:0] y_q, y_d, ny_q, ny_d, py;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        nx_d = nx_q;
        ny_d = ny_q;
        px   = sync ? 10'd0 : nx_q;
        py   = sync ? 9'd0 : ny_q;
        if (load) begin
            x_d = px;
            y_d = py;
            // An early end of line behaves exactly like a natural wrap.
            if (brk || (px == X_LAST)) begin
                nx_d = 10'd0;
                ny_d = (py == Y_LAST) ? 9'd0 : py + 9'd1;
            end else begin
                nx_d = px + 10'd1;
                ny_d = py;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q  <= 10'd0;
            y_q  <= 9'd0;
            nx_q <= 10'd0;
            ny_q <= 9'd0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            nx_q <= nx_d;
            ny_q <= ny_d;
        end
    end

    assign pix_x   = x_q;
    assign pix_y   = y_q;
    assign next_x  = nx_q;
    assign next_y  = ny_q;
    assign pix_sof = (x_q == 10'd0) && (y_q == 9'd0);
    assign pix_eol = (x_q == X_LAST);

endmodule

// File: rtl/stream_unpacker.sv
// Unpacks 3-word/4-pixel packed 24-bit video into one pixel per handshake,
// with frame/line resynchronisation and sticky framing-error flags.
module stream_unpacker
    import video_stream_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    input  logic        err_clr,
    output logic        err_sof,
    output logic        err_eol,
    output logic [1:0]  dbg_state
);

    // Handshakes: a word moves when in_stream_tvalid & in_stream_tready, a pixel
    // moves when pix_valid & pix_ready; neither valid depends on its ready.
    localparam logic [9:0] X_PEN = 10'(X_SIZE - 2);

    logic [1:0]  state_q, state_d, phase_q, phase_d, eff_ph;
    logic [15:0] res_q, res_d;
    logic [23:0] pend_q, pend_d, pix_q, pix_d;
    logic        cut_q, cut_d, init_q, init_d;
    logic        err_sof_q, err_sof_d, err_eol_q, err_eol_d;
    logic        acc, hs, sof_bad, eol_word, eol_bad, cut_line;
    logic        cnt_load, cnt_sync, cnt_brk;
    logic [9:0]  next_x;
    logic [8:0]  next_y;
    logic [31:0] w;
    logic        unused_tkeep;

    assign unused_tkeep = ^in_stream_tkeep;
    assign w            = in_stream_tdata;

    assign pix_valid        = (state_q != ST_EMPTY);
    assign in_stream_tready = init_q & ((state_q == ST_EMPTY) | ((state_q == ST_HOLD) & pix_ready));
    assign acc              = in_stream_tvalid & in_stream_tready;
    assign hs               = pix_valid & pix_ready;

    // A misplaced start of frame re-decodes the word as W0 at (0,0).
    assign sof_bad  = in_stream_tuser & ((phase_q != PH_W0) | (|next_x) | (|next_y));
    assign eff_ph   = sof_bad ? PH_W0 : phase_q;
    assign eol_word = (eff_ph == PH_W2) & (next_x == X_PEN);
    assign eol_bad  = in_stream_tlast ^ eol_word;
    assign cut_line = in_stream_tlast & ~eol_word;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        res_d     = res_q;
        pend_d    = pend_q;
        pix_d     = pix_q;
        cut_d     = cut_q;
        init_d    = 1'b1;
        cnt_load  = 1'b0;
        cnt_sync  = 1'b0;
        cnt_brk   = 1'b0;
        err_sof_d = err_clr ? 1'b0 : err_sof_q;
        err_eol_d = err_clr ? 1'b0 : err_eol_q;
        if (acc) begin
            cnt_load = 1'b1;
            cnt_sync = sof_bad;
            if (sof_bad) err_sof_d = 1'b1;
            if (eol_bad) err_eol_d = 1'b1;
            phase_d = cut_line ? PH_W0 : phase_next(eff_ph);
            case (eff_ph)
                PH_W1: begin
                    pix_d   = {w[15:0], res_q[7:0]};
                    res_d   = w[31:16];
                    state_d = ST_HOLD;
                    cnt_brk = cut_line;
                end
                PH_W2: begin
                    // The line break, if any, belongs after p3, not p2.
                    pix_d   = {w[7:0], res_q};
                    pend_d  = w[31:8];
                    state_d = ST_HOLD2;
                    cut_d   = cut_line;
                end
                default: begin
                    pix_d   = w[23:0];
                    res_d   = {8'h00, w[31:24]};
                    state_d = ST_HOLD;
                    cnt_brk = cut_line;
                end
            endcase
        end else if ((state_q == ST_HOLD2) && hs) begin
            pix_d    = pend_q;
            state_d  = ST_HOLD;
            cnt_load = 1'b1;
            cnt_brk  = cut_q;
            cut_d    = 1'b0;
        end else if ((state_q == ST_HOLD) && hs) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_EMPTY;
            phase_q   <= PH_W0;
            res_q     <= 16'h0000;
            pend_q    <= 24'h000000;
            pix_q     <= 24'h000000;
            cut_q     <= 1'b0;
            init_q    <= 1'b0;
            err_sof_q <= 1'b0;
            err_eol_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            res_q     <= res_d;
            pend_q    <= pend_d;
            pix_q     <= pix_d;
            cut_q     <= cut_d;
            init_q    <= init_d;
            err_sof_q <= err_sof_d;
            err_eol_q <= err_eol_d;
        end
    end

    pixel_counter #(
        .X_SIZE(X_SIZE),
        .Y_SIZE(Y_SIZE)
    ) u_counter (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (cnt_load),
        .sync    (cnt_sync),
        .brk     (cnt_brk),
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .next_x  (next_x),
        .next_y  (next_y),
        .pix_sof (pix_sof),
        .pix_eol (pix_eol)
    );

    assign pix_r     = pix_q[23:16];
    assign pix_g     = pix_q[15:8];
    assign pix_b     = pix_q[7:0];
    assign err_sof   = err_sof_q;
    assign err_eol   = err_eol_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker at an 8x2 frame: a position/queue model of the
// pixel stream is checked against every delivered pixel, plus literal spot values.
module tb_stream_unpacker;

    localparam int XS = 8;
    localparam int YS = 2;
    localparam int EW = 44;   // {hold2, y[8:0], x[9:0], pixel[23:0]}

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hf;
    logic        tlast = 1'b0, tuser = 1'b0, tvalid = 1'b0;
    logic        tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic        err_sof, err_eol;
    logic [1:0]  dbg_state;

    int checks = 0;
    int passed = 0;
    int delivered = 0;
    int mx = 0, my = 0;
    int rdy_mode = 0;   // 0: ready high, 1: toggle, 2: left to the main flow
    logic [EW-1:0] exp_q[$];

    stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
        .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .err_clr(err_clr), .err_sof(err_sof), .err_eol(err_eol), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rdy_mode == 1) pix_ready = ~pix_ready;
        else if (rdy_mode == 0) pix_ready = 1'b1;
    end

    // ---------------- model helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    task automatic push_px(input logic [23:0] p, input logic h2);
        exp_q.push_back({h2, 9'(my), 10'(mx), p});
        mx++;
        if (mx == XS) begin
            mx = 0;
            my = (my + 1) % YS;
        end
    endtask

    function automatic logic [95:0] pack4(input logic [23:0] p0, p1, p2, p3);
        logic [31:0] w0, w1, w2;
        w0 = {p1[7:0], p0};
        w1 = {p2[15:0], p1[23:8]};
        w2 = {p3, p2[23:16]};
        return {w2, w1, w0};
    endfunction

    // ---------------- driver ----------------
    task automatic send_word(input logic [31:0] w, input logic u, input logic l);
        int n = 0;
        tdata = w; tuser = u; tlast = l; tvalid = 1'b1;
        @(negedge aclk);
        while (!tready && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("word_accept", {63'd0, tready}, 64'd1);
        @(posedge aclk);
        #1;
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_group(input logic [23:0] p0, p1, p2, p3, input logic u, input logic l);
        logic [95:0] ws;
        ws = pack4(p0, p1, p2, p3);
        push_px(p0, 1'b0);
        push_px(p1, 1'b0);
        push_px(p2, 1'b1);
        push_px(p3, 1'b0);
        send_word(ws[31:0], u, 1'b0);
        send_word(ws[63:32], 1'b0, 1'b0);
        send_word(ws[95:64], 1'b0, l);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
        check("err_cleared", {62'd0, err_sof, err_eol}, 64'd0);
    endtask

    // ---------------- scoreboard ----------------
    logic [45:0] prev_out;
    logic        prev_stall = 1'b0;

    always @(negedge aclk) begin
        logic [45:0]   cur;
        logic [EW-1:0] e;
        logic [44:0]   got, want;
        cur = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, pix_valid};
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", 64'(cur), 64'(prev_out));
            if (pix_valid && !pix_ready) check("tready_in_stall", {63'd0, tready}, 64'd0);
            if (pix_valid && exp_q.size() > 0 && exp_q[0][EW-1])
                check("tready_hold2", {63'd0, tready}, 64'd0);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    want = {e[23:0], e[33:24], e[42:34],
                            (e[33:24] == 10'd0) && (e[42:34] == 9'd0),
                            (e[33:24] == 10'(XS - 1))};
                    got  = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
                    check("pixel", 64'(got), 64'(want));
                    delivered++;
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_out   = cur;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [95:0] ws;
        repeat (3) @(negedge aclk);
        check("reset_outputs",
              64'({pix_valid, tready, pix_r, pix_g, pix_b, pix_x, pix_y, err_sof, err_eol}), 64'd0);
        aresetn = 1'b1;
        #1;
        check("tready_before_clock", {63'd0, tready}, 64'd0);
        @(posedge aclk);
        #1;
        check("tready_after_clock", {63'd0, tready}, 64'd1);

        // One clean 8x2 frame of pixels 1..16.
        send_group(24'd1, 24'd2, 24'd3, 24'd4, 1'b1, 1'b0);
        send_group(24'd5, 24'd6, 24'd7, 24'd8, 1'b0, 1'b1);
        send_group(24'd9, 24'd10, 24'd11, 24'd12, 1'b0, 1'b0);
        send_group(24'd13, 24'd14, 24'd15, 24'd16, 1'b0, 1'b1);
        wait_drain();
        check("frame_count", 64'(delivered), 64'd16);
        check("frame_no_err", {62'd0, err_sof, err_eol}, 64'd0);

        // Literal packing example, first pixel one cycle after acceptance.
        push_px(24'h332211, 1'b0);
        push_px(24'h665544, 1'b0);
        push_px(24'h998877, 1'b1);
        push_px(24'hCCBBAA, 1'b0);
        send_word(32'h44332211, 1'b1, 1'b0);
        check("latency_first_pixel", 64'({pix_valid, pix_r, pix_g, pix_b}), 64'h1332211);
        send_word(32'h88776655, 1'b0, 1'b0);
        send_word(32'hCCBBAA99, 1'b0, 1'b0);
        send_group(24'h100, 24'h101, 24'h102, 24'h103, 1'b0, 1'b1);
        wait_drain();

        // Downstream ready toggling 1010 over a whole line.
        rdy_mode = 1;
        send_group(24'h200, 24'h201, 24'h202, 24'h203, 1'b0, 1'b0);
        send_group(24'h204, 24'h205, 24'h206, 24'h207, 1'b0, 1'b1);
        wait_drain();
        rdy_mode = 0;
        pix_ready = 1'b1;

        // Early tlast on the 4th word of line 0.
        send_group(24'h300, 24'h301, 24'h302, 24'h303, 1'b0, 1'b0);
        ws = pack4(24'h310, 24'h311, 24'h312, 24'h313);
        push_px(24'h310, 1'b0);
        send_word(ws[31:0], 1'b0, 1'b1);
        mx = 0;
        my = (my + 1) % YS;
        wait_drain();
        check("early_tlast_err", {62'd0, err_sof, err_eol}, 64'd1);
        clear_errs();
        ws = pack4(24'h320, 24'h321, 24'h322, 24'h323);
        push_px(24'h320, 1'b0);
        push_px(24'h321, 1'b0);
        push_px(24'h322, 1'b1);
        push_px(24'h323, 1'b0);
        send_word(ws[31:0], 1'b0, 1'b0);
        check("after_break_pos", 64'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b}),
              64'({1'b1, 10'd0, 9'd1, 24'h000320}));
        send_word(ws[63:32], 1'b0, 1'b0);
        send_word(ws[95:64], 1'b0, 1'b0);
        send_group(24'h324, 24'h325, 24'h326, 24'h327, 1'b0, 1'b1);
        wait_drain();

        // tuser on the 2nd word of a line resyncs to (0,0).
        ws = pack4(24'h400, 24'h401, 24'h402, 24'h403);
        push_px(24'h400, 1'b0);
        send_word(ws[31:0], 1'b1, 1'b0);
        mx = 0;
        my = 0;
        ws = pack4(24'h410, 24'h411, 24'h412, 24'h413);
        push_px(24'h410, 1'b0);
        push_px(24'h411, 1'b0);
        push_px(24'h412, 1'b1);
        push_px(24'h413, 1'b0);
        send_word(ws[31:0], 1'b1, 1'b0);
        check("resync_pos", 64'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b}),
              64'({1'b1, 10'd0, 9'd0, 24'h000410}));
        send_word(ws[63:32], 1'b0, 1'b0);
        send_word(ws[95:64], 1'b0, 1'b0);
        send_group(24'h414, 24'h415, 24'h416, 24'h417, 1'b0, 1'b1);
        wait_drain();
        check("sof_err", {62'd0, err_sof, err_eol}, 64'd2);
        clear_errs();

        // Missing tlast at the end of line 1: flagged, counting continues.
        send_group(24'h500, 24'h501, 24'h502, 24'h503, 1'b0, 1'b0);
        send_group(24'h504, 24'h505, 24'h506, 24'h507, 1'b0, 1'b0);
        wait_drain();
        check("missing_tlast_err", {62'd0, err_sof, err_eol}, 64'd1);
        clear_errs();

        // A new error in the same cycle as err_clr wins.
        ws = pack4(24'h600, 24'h601, 24'h602, 24'h603);
        push_px(24'h600, 1'b0);
        err_clr = 1'b1;
        send_word(ws[31:0], 1'b0, 1'b1);
        err_clr = 1'b0;
        mx = 0;
        my = (my + 1) % YS;
        check("err_beats_clear", {62'd0, err_sof, err_eol}, 64'd1);
        wait_drain();
        clear_errs();

        // Reset while p2 is held and p3 pending.
        send_group(24'h700, 24'h701, 24'h702, 24'h703, 1'b0, 1'b0);
        rdy_mode = 2;
        pix_ready = 1'b0;
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check("reset_mid_hold2",
              64'({pix_valid, tready, pix_r, pix_g, pix_b, pix_x, pix_y, err_sof, err_eol}), 64'd0);
        exp_q.delete();
        mx = 0;
        my = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        rdy_mode = 0;
        pix_ready = 1'b1;
        #1;
        check("tready_before_clock2", {63'd0, tready}, 64'd0);
        @(posedge aclk);
        #1;
        check("tready_after_clock2", {63'd0, tready}, 64'd1);
        ws = pack4(24'h800, 24'h801, 24'h802, 24'h803);
        push_px(24'h800, 1'b0);
        push_px(24'h801, 1'b0);
        push_px(24'h802, 1'b1);
        push_px(24'h803, 1'b0);
        send_word(ws[31:0], 1'b0, 1'b0);
        check("post_reset_w0", 64'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b}),
              64'({1'b1, 10'd0, 9'd0, 24'h000800}));
        send_word(ws[63:32], 1'b0, 1'b0);
        send_word(ws[95:64], 1'b0, 1'b0);
        wait_drain();
        check("post_reset_no_err", {62'd0, err_sof, err_eol}, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
